// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants for the ROM port arbiter: bus/word widths, ROM defaults,
// requester identifiers and the address range check.
package rom_port_arbiter_pkg;

  localparam int unsigned BUS_W  = 64;
  localparam int unsigned WORD_W = 32;

  localparam logic [BUS_W-1:0] ROM_START_DEF = 64'h0;
  localparam logic [BUS_W-1:0] ROM_SIZE_DEF  = 64'd256;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // A 4-byte read must fit entirely inside the ROM window (unsigned 64-bit).
  function automatic logic addr_in_range(input logic [BUS_W-1:0] addr,
                                         input logic [BUS_W-1:0] start,
                                         input logic [BUS_W-1:0] size);
    return (addr >= start) && ((addr - start) <= (size - 64'd4));
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Request/response channels of the two requesters plus the ROM read port.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// a requester holds valid/addr until ready, a response holds data/err until ready.
interface rom_port_arbiter_if;
  import rom_port_arbiter_pkg::*;

  logic              if_req_valid;
  logic [BUS_W-1:0]  if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [WORD_W-1:0] if_rsp_data;
  logic              if_rsp_err;
  logic              if_rsp_ready;

  logic              d_req_valid;
  logic [BUS_W-1:0]  d_req_addr;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [BUS_W-1:0]  d_rsp_data;
  logic              d_rsp_err;
  logic              d_rsp_ready;

  logic [BUS_W-1:0]  rom_haddr;
  logic [BUS_W-1:0]  rom_hwdata;
  logic [BUS_W-1:0]  rom_hrdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    input  rom_hrdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output rom_haddr, rom_hwdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output d_req_valid, d_req_addr, d_rsp_ready,
    output rom_hrdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  rom_haddr, rom_hwdata
  );

endinterface

// File: rtl/rom_port_arbiter_rsp_slot.sv
// One-entry response register with valid/ready; a load in the same cycle as a
// drain overwrites the slot so a requester can sustain one response per cycle.
module rom_rsp_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_err,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
            rsp_err   <= load_err;
        end else if (rsp_valid && rsp_ready) begin
            // Data/err deliberately keep their last values after a drain.
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational ROM read port between instruction fetch and data
// load: D wins by default, IF is forced through after STARVE_LIMIT denials.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter logic [BUS_W-1:0] ROM_SIZE     = ROM_SIZE_DEF,
    parameter logic [BUS_W-1:0] ROM_START    = ROM_START_DEF,
    parameter int unsigned      STARVE_LIMIT = 4
) (
    input  logic               HCLK,
    input  logic               HRESET,
    rom_port_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic              if_free;
    logic              d_free;
    logic              if_elig;
    logic              d_elig;
    logic              starved;
    logic              grant_if;
    logic              grant_d;
    req_id_e           grant_id;
    logic [BUS_W-1:0]  gnt_addr;
    logic              addr_ok;
    logic [WORD_W-1:0] if_load_data;
    logic [BUS_W-1:0]  d_load_data;
    logic [CNT_W-1:0]  starve_cnt;

    // A slot can accept a new response if empty or being drained this cycle.
    assign if_free = !bus.if_rsp_valid || bus.if_rsp_ready;
    assign d_free  = !bus.d_rsp_valid  || bus.d_rsp_ready;
    assign if_elig = bus.if_req_valid && if_free;
    assign d_elig  = bus.d_req_valid  && d_free;
    assign starved = (starve_cnt == CNT_MAX);

    always_comb begin
        grant_if = if_elig && (!d_elig || starved);
        grant_d  = d_elig && !grant_if;
        grant_id = grant_d ? REQ_D : REQ_IF;
        gnt_addr = '0;
        if (grant_if || grant_d) begin
            gnt_addr = (grant_id == REQ_D) ? bus.d_req_addr : bus.if_req_addr;
        end
    end

    assign bus.if_req_ready = grant_if;
    assign bus.d_req_ready  = grant_d;
    assign bus.rom_haddr    = gnt_addr;
    assign bus.rom_hwdata   = '0;

    // The ROM returns data in the low word only; out-of-range reads yield zero.
    assign addr_ok      = addr_in_range(gnt_addr, ROM_START, ROM_SIZE);
    assign if_load_data = addr_ok ? bus.rom_hrdata[WORD_W-1:0] : '0;
    assign d_load_data  = addr_ok ? bus.rom_hrdata : '0;

    // Counts IF denials while it could have been served; a blocked IF slot
    // neither advances nor clears the count.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            starve_cnt <= '0;
        end else if (!bus.if_req_valid || grant_if) begin
            starve_cnt <= '0;
        end else if (if_elig && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    rom_rsp_slot #(
        .W (WORD_W)
    ) u_if_slot (
        .clk       (HCLK),
        .rst       (HRESET),
        .load      (grant_if),
        .load_data (if_load_data),
        .load_err  (!addr_ok),
        .rsp_ready (bus.if_rsp_ready),
        .rsp_valid (bus.if_rsp_valid),
        .rsp_data  (bus.if_rsp_data),
        .rsp_err   (bus.if_rsp_err)
    );

    rom_rsp_slot #(
        .W (BUS_W)
    ) u_d_slot (
        .clk       (HCLK),
        .rst       (HRESET),
        .load      (grant_d),
        .load_data (d_load_data),
        .load_err  (!addr_ok),
        .rsp_ready (bus.d_rsp_ready),
        .rsp_valid (bus.d_rsp_valid),
        .rsp_data  (bus.d_rsp_data),
        .rsp_err   (bus.d_rsp_err)
    );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rom_port_arbiter;

  localparam logic [63:0] ROM_START = 64'h0;
  localparam logic [63:0] ROM_SIZE  = 64'd256;
  localparam int          LIMIT     = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rom_port_arbiter_if bus ();

  rom_port_arbiter #(
    .ROM_SIZE     (ROM_SIZE),
    .ROM_START    (ROM_START),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM image ----------------
  function automatic logic [7:0] rom_byte(input logic [63:0] i);
    case (i)
      64'd0: return 8'h83;
      64'd1: return 8'h30;
      64'd2: return 8'h80;
      64'd3: return 8'h01;
      64'd4: return 8'h93;
      64'd5: return 8'h80;
      64'd6: return 8'h10;
      64'd7: return 8'h00;
      default: return i[7:0];
    endcase
  endfunction

  // Out-of-window reads return garbage so the arbiter must mask them.
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    if (a > 64'd252) return 32'hDEADBEEF;
    return {rom_byte(a + 3), rom_byte(a + 2), rom_byte(a + 1), rom_byte(a)};
  endfunction

  always_comb bus.rom_hrdata = {32'h0, rom_word(bus.rom_haddr)};

  // ---------------- behavioural model ----------------
  logic        m_if_v, m_if_err, m_d_v, m_d_err;
  logic [31:0] m_if_data;
  logic [63:0] m_d_data;
  int          m_denied;

  function automatic logic in_window(input logic [63:0] a);
    return (a >= ROM_START) && ((a - ROM_START) <= (ROM_SIZE - 64'd4));
  endfunction

  task automatic model_reset();
    m_if_v = 0; m_if_err = 0; m_if_data = '0;
    m_d_v = 0; m_d_err = 0; m_d_data = '0;
    m_denied = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compares all outputs against the model, then advances the model by one edge.
  task automatic check_cycle();
    logic if_ok, d_ok, gi, gd;
    logic [63:0] exp_addr;
    if_ok = bus.if_req_valid && (!m_if_v || bus.if_rsp_ready);
    d_ok  = bus.d_req_valid  && (!m_d_v  || bus.d_rsp_ready);
    gi = if_ok && (!d_ok || m_denied == LIMIT);
    gd = d_ok && !gi;
    exp_addr = gi ? bus.if_req_addr : (gd ? bus.d_req_addr : 64'h0);

    chk("if_req_ready", bus.if_req_ready, gi);
    chk("d_req_ready",  bus.d_req_ready,  gd);
    chk("rom_haddr",    bus.rom_haddr,    exp_addr);
    chk("rom_hwdata",   bus.rom_hwdata,   64'h0);
    chk("if_rsp_valid", bus.if_rsp_valid, m_if_v);
    chk("if_rsp_err",   bus.if_rsp_err,   m_if_err);
    chk("if_rsp_data",  bus.if_rsp_data,  m_if_data);
    chk("d_rsp_valid",  bus.d_rsp_valid,  m_d_v);
    chk("d_rsp_err",    bus.d_rsp_err,    m_d_err);
    chk("d_rsp_data",   bus.d_rsp_data,   m_d_data);

    if (gi) begin
      m_if_v = 1;
      m_if_err = !in_window(bus.if_req_addr);
      m_if_data = m_if_err ? 32'h0 : rom_word(bus.if_req_addr);
    end else if (m_if_v && bus.if_rsp_ready) begin
      m_if_v = 0;
    end
    if (gd) begin
      m_d_v = 1;
      m_d_err = !in_window(bus.d_req_addr);
      m_d_data = m_d_err ? 64'h0 : {32'h0, rom_word(bus.d_req_addr)};
    end else if (m_d_v && bus.d_rsp_ready) begin
      m_d_v = 0;
    end
    if (!bus.if_req_valid || gi) m_denied = 0;
    else if (if_ok && m_denied < LIMIT) m_denied = m_denied + 1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic iv, input logic [63:0] ia, input logic irr,
                      input logic dv, input logic [63:0] da, input logic drr);
    @(posedge clk);
    #1;
    bus.if_req_valid = iv; bus.if_req_addr = ia; bus.if_rsp_ready = irr;
    bus.d_req_valid  = dv; bus.d_req_addr  = da; bus.d_rsp_ready  = drr;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle();
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 9) < 8) return 64'($urandom_range(0, 262));
    return {$urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  logic [5:0] if_rdy_seq, d_rdy_seq;
  logic [63:0] held;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.if_req_valid = 0; bus.if_req_addr = '0; bus.if_rsp_ready = 0;
    bus.d_req_valid  = 0; bus.d_req_addr  = '0; bus.d_rsp_ready  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_if_valid", bus.if_rsp_valid, 1'b0);
    chk("reset_d_valid",  bus.d_rsp_valid,  1'b0);
    chk("reset_if_data",  bus.if_rsp_data,  32'h0);
    chk("reset_d_data",   bus.d_rsp_data,   64'h0);
    chk("reset_errs",     {bus.if_rsp_err, bus.d_rsp_err}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;

    // IF fetch of word 0
    step(1, 64'd0, 1, 0, 64'd0, 1);
    idle();
    chk("if0_valid", bus.if_rsp_valid, 1'b1);
    chk("if0_data",  bus.if_rsp_data,  32'h01803083);
    chk("if0_err",   bus.if_rsp_err,   1'b0);

    // D load at 24
    step(0, 64'd0, 1, 1, 64'd24, 1);
    idle();
    chk("d24_data", bus.d_rsp_data, 64'h000000001B1A1918);
    chk("d24_err",  bus.d_rsp_err,  1'b0);

    // Contention: D first, IF next
    step(1, 64'd4, 1, 1, 64'd16, 1);
    chk("both_d_wins", {bus.d_req_ready, bus.if_req_ready}, 2'b10);
    step(1, 64'd4, 1, 0, 64'd0, 1);
    chk("both_if_next", bus.if_req_ready, 1'b1);
    chk("both_d_data",  bus.d_rsp_data, 64'h13121110);
    idle();
    chk("both_if_data", bus.if_rsp_data, 32'h00108093);

    // Starvation: IF forced through on the fifth cycle
    idle();
    for (int c = 0; c < 6; c++) begin
      step(1, 64'($urandom_range(0, 252)), 1, 1, 64'($urandom_range(0, 252)), 1);
      if_rdy_seq[c] = bus.if_req_ready;
      d_rdy_seq[c]  = bus.d_req_ready;
    end
    chk("starve_if_seq", if_rdy_seq, 6'b010000);
    chk("starve_d_seq",  d_rdy_seq,  6'b101111);

    // Range boundaries
    step(0, 64'd0, 1, 1, 64'd252, 1);
    step(0, 64'd0, 1, 1, 64'd253, 1);
    chk("d252_data", bus.d_rsp_data, 64'hFFFEFDFC);
    chk("d252_err",  bus.d_rsp_err,  1'b0);
    step(1, 64'hFFFFFFFFFFFFFFF0, 1, 0, 64'd0, 1);
    chk("d253_err",  bus.d_rsp_err,  1'b1);
    chk("d253_data", bus.d_rsp_data, 64'h0);
    idle();
    chk("if_big_err",  bus.if_rsp_err,  1'b1);
    chk("if_big_data", bus.if_rsp_data, 32'h0);

    // Backpressure on D while IF keeps flowing
    step(0, 64'd0, 1, 1, 64'd32, 1);
    for (int c = 0; c < 3; c++) begin
      step(1, 64'(8 * c), 1, 1, 64'd40, 0);
      chk("bp_d_ready",  bus.d_req_ready,  1'b0);
      chk("bp_d_valid",  bus.d_rsp_valid,  1'b1);
      chk("bp_d_data",   bus.d_rsp_data,   64'h23222120);
      chk("bp_if_ready", bus.if_req_ready, 1'b1);
    end

    // Asynchronous reset in the middle of the hold
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_if_valid", bus.if_rsp_valid, 1'b0);
    chk("arst_d_valid",  bus.d_rsp_valid,  1'b0);
    chk("arst_d_data",   bus.d_rsp_data,   64'h0);
    bus.if_req_valid = 0; bus.d_req_valid = 0;
    bus.if_rsp_ready = 1; bus.d_rsp_ready = 1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 6);
    end

    held = 64'(n_fail);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational read port of the boot/instruction ROM between two requesters: instruction fetch (IF) and data load (D).
- Arbitrates each cycle and drives the ROM address from the granted requester.
- Captures ROM read data into per-requester response registers, giving 1-cycle latency with valid/ready backpressure.
- Range-checks addresses and returns an error flag instead of ROM data.

Parameters:
ROM_SIZE, 256, ROM size in bytes; must match the ROM instance.
ROM_START, 64'h0, ROM base address; must match the ROM instance.
STARVE_LIMIT, 4, consecutive cycles IF may be denied while valid before it is forced to win; must be ≥1.

Ports:
HCLK  in  1  clock; all state on rising edge.
HRESET  in  1  asynchronous, active-high reset.
if_req_valid  in  1  IF request.
if_req_addr  in  64  IF byte address.
if_req_ready  out  1  IF request accepted this cycle.
if_rsp_valid  out  1  IF response held.
if_rsp_data  out  32  instruction word.
if_rsp_err  out  1  IF address out of range.
if_rsp_ready  in  1  IF consumer takes response.
d_req_valid  in  1  D request.
d_req_addr  in  64  D byte address.
d_req_ready  out  1  D request accepted this cycle.
d_rsp_valid  out  1  D response held.
d_rsp_data  out  64  load data.
d_rsp_err  out  1  D address out of range.
d_rsp_ready  in  1  D consumer takes response.
rom_haddr  out  64  ROM address.
rom_hwdata  out  64  tied to 0.
rom_hrdata  in  64  ROM data, combinational from rom_haddr; upper 32 bits are zero.

Behaviour:
- Reset (asynchronous, any time): all rsp_valid/err = 0, all rsp_data = 0, starve_cnt = 0. In-flight requests and held responses are dropped.
- Slot free:
  - slot_free_X = !X_rsp_valid | X_rsp_ready.
  - A requester is eligible iff X_req_valid & slot_free_X.
- Arbitration (combinational, each cycle):
  - Default: D has priority over IF.
  - If starve_cnt == STARVE_LIMIT and IF is eligible, IF wins.
  - Exactly one grant or none. X_req_ready = grant_X.
- ROM address:
  - rom_haddr = address of the granted requester.
  - 64'h0 when no grant.
- Range check: in_range = (addr >= ROM_START) && (addr - ROM_START <= ROM_SIZE-4), computed in 64-bit unsigned arithmetic.
- Capture on the rising edge when grant_X is asserted:
  - X_rsp_valid ← 1.
  - X_rsp_err ← !in_range.
  - Data: IF takes rom_hrdata[31:0]; D takes rom_hrdata zero-extended to 64 bits. Data is 0 when out of range.
  - Latency: response is visible exactly 1 cycle after the request handshake.
- Response release:
  - If X_rsp_ready & X_rsp_valid and there is no new grant to X, then X_rsp_valid ← 0. Data/err hold their values.
  - Simultaneous drain and new grant: the slot is overwritten, valid stays 1, giving back-to-back throughput of 1 per cycle per requester.
- Stability: while X_rsp_valid & !X_rsp_ready, data/err are stable and X_req_ready = 0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when IF is eligible and not granted.
  - Clears when IF is granted, or when if_req_valid = 0.
  - Holds its value when IF is valid but its slot is blocked.
- Alignment: no alignment check; unaligned addresses read 4 consecutive bytes.
- No combinational path from rsp_ready to rsp_data; rsp_ready → req_ready is combinational (allowed).

Decomposition:
- Shared package (rom_pkg): ROM_START/ROM_SIZE defaults, ROM word width (32), bus width (64), and requester-ID constants REQ_IF = 0, REQ_D = 1.
- One natural sub-module: rom_rsp_slot. It is the 1-entry response register with valid/ready and a data-width parameter, instantiated twice (32-bit for IF, 64-bit for D).
- Arbitration and the starvation counter stay in the top module.

Test Plan:
- IF reads addr 0; ROM byte i = i for i ≥ 16 and word0 = 0x01803083 → if_rsp_valid and if_rsp_data = 0x01803083 the next cycle, err = 0.
- D reads addr 24 → next cycle d_rsp_data = 0x000000001B1A1918, err = 0.
- Both valid at addr 4 (IF) and 16 (D), both rsp_ready = 1:
  - cycle 0: D granted (d_rsp_data = 0x13121110 next cycle);
  - cycle 1: IF granted, data = 0x00108093.
- D valid continuously, IF valid from cycle 0, STARVE_LIMIT = 4 → IF is denied cycles 0–3 and granted in cycle 4; D is denied in cycle 4 and granted again in cycle 5.
- ROM_SIZE = 256:
  - D addr 252 → data 0xFFFEFDFC, err = 0.
  - D addr 253 → err = 1, data 0.
  - IF addr 0xFFFFFFFFFFFFFFF0 → err = 1.
- Backpressure:
  - d_rsp_ready = 0 for 3 cycles → d_rsp_valid and data stay stable, d_req_ready = 0, and IF requests are still served.
  - Assert HRESET mid-hold → all rsp_valid drop immediately (asynchronously) to 0.
